// File: rtl/vgg_pkg.sv
// Shared constants and helpers for the VGG feature-extraction pipeline stages.
// VGG_CHECK_EVEN stops elaboration when a pooled dimension is odd.
`ifndef VGG_PKG_SV
`define VGG_PKG_SV

`define VGG_CHECK_EVEN(LBL, N) \
    if (((N) % 2) != 0) begin : LBL \
        $error("pooled dimension must be even"); \
    end

package vgg_pkg;

    localparam int CH   = 8;
    localparam int POOL = 2;

    // LSB position of channel k in a packed pixel of dw-bit samples.
    function automatic int unsigned ch_lsb(input int unsigned k, input int unsigned dw);
        return k * dw;
    endfunction

endpackage

`endif

// File: rtl/max_cmp.sv
// Channelwise signed maximum of two packed CH-channel pixels (combinational).
// Ties return a_i; callers feed the earlier sample on a_i.
module max_cmp #(
    parameter int DATA_WIDTH = 32,
    parameter int CH         = vgg_pkg::CH
) (
    input  logic [DATA_WIDTH*CH-1:0] a_i,
    input  logic [DATA_WIDTH*CH-1:0] b_i,
    output logic [DATA_WIDTH*CH-1:0] max_o
);
    import vgg_pkg::*;

    for (genvar k = 0; k < CH; k++) begin : g_ch
        localparam int unsigned LSB = ch_lsb(k, DATA_WIDTH);
        logic signed [DATA_WIDTH-1:0] a;
        logic signed [DATA_WIDTH-1:0] b;

        assign a = a_i[LSB +: DATA_WIDTH];
        assign b = b_i[LSB +: DATA_WIDTH];
        assign max_o[LSB +: DATA_WIDTH] = (b > a) ? b : a;
    end

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over an 8-channel raster pixel stream.
// Even rows park horizontal maxima in a half-width line buffer; odd rows finish the window.
module maxpool2x2_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int CH         = vgg_pkg::CH,
    parameter int WIDTH      = 112,
    parameter int HEIGHT     = 112
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH*CH-1:0] i_data,
    input  logic                     valid_in,
    output logic [DATA_WIDTH*CH-1:0] o_data,
    output logic                     valid_out,
    output logic                     last_out
);
    import vgg_pkg::*;

    localparam int PW = DATA_WIDTH * CH;
    localparam int OW = WIDTH / POOL;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int AW = (OW > 1) ? $clog2(OW) : 1;

    `VGG_CHECK_EVEN(g_width_even, WIDTH)
    `VGG_CHECK_EVEN(g_height_even, HEIGHT)

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [PW-1:0] h_reg_q;
    logic [PW-1:0] o_data_q;
    logic          valid_out_q;
    logic          last_out_q;

    logic [PW-1:0] lbuf_q [OW];
    logic [AW-1:0] lb_addr;
    logic [PW-1:0] lb_rd;
    logic [PW-1:0] hmax;
    logic [PW-1:0] vmax;
    logic          col_end;
    logic          row_end;
    logic          lb_wr;

    assign col_end = (col_q == CW'(WIDTH - 1));
    assign row_end = (row_q == RW'(HEIGHT - 1));
    assign lb_addr = AW'(col_q >> 1);
    assign lb_rd   = lbuf_q[lb_addr];

    max_cmp #(.DATA_WIDTH(DATA_WIDTH), .CH(CH)) u_hmax (
        .a_i   (h_reg_q),
        .b_i   (i_data),
        .max_o (hmax)
    );

    // Line-buffer entry is the upper pair, so it is the earlier operand.
    max_cmp #(.DATA_WIDTH(DATA_WIDTH), .CH(CH)) u_vmax (
        .a_i   (lb_rd),
        .b_i   (hmax),
        .max_o (vmax)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (valid_in) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    assign lb_wr = rst && valid_in && col_q[0] && !row_q[0];

    // Contents are don't-care after reset, so the buffer carries no reset.
    always_ff @(posedge clk) begin
        if (lb_wr) begin
            lbuf_q[lb_addr] <= hmax;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            h_reg_q     <= '0;
            o_data_q    <= '0;
            valid_out_q <= 1'b0;
            last_out_q  <= 1'b0;
        end else begin
            valid_out_q <= 1'b0;
            last_out_q  <= 1'b0;
            col_q       <= col_d;
            row_q       <= row_d;
            if (valid_in) begin
                if (!col_q[0]) begin
                    h_reg_q <= i_data;
                end else if (row_q[0]) begin
                    o_data_q    <= vmax;
                    valid_out_q <= 1'b1;
                    last_out_q  <= col_end && row_end;
                end
            end
        end
    end

    assign o_data    = o_data_q;
    assign valid_out = valid_out_q;
    assign last_out  = last_out_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: a 4x4 instance for directed vectors and a 112x112
// instance for a random frame, both checked every cycle against a frame-array model.
module tb_maxpool2x2_stream;
    localparam int DW = 32;
    localparam int CH = 8;
    localparam int W  = DW * CH;
    localparam int LN = 112;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] s_in = '0, s_out, l_in = '0, l_out;
    logic s_vin = 1'b0, s_vout, s_lout;
    logic l_vin = 1'b0, l_vout, l_lout;

    maxpool2x2_stream #(.DATA_WIDTH(DW), .CH(CH), .WIDTH(4), .HEIGHT(4)) u_s (
        .clk(clk), .rst(rst), .i_data(s_in), .valid_in(s_vin),
        .o_data(s_out), .valid_out(s_vout), .last_out(s_lout));

    maxpool2x2_stream #(.DATA_WIDTH(DW), .CH(CH), .WIDTH(LN), .HEIGHT(LN)) u_l (
        .clk(clk), .rst(rst), .i_data(l_in), .valid_in(l_vin),
        .o_data(l_out), .valid_out(l_vout), .last_out(l_lout));

    int vectors = 0;
    int miscompares = 0;

    // stimulus for the next step
    logic nxt_rst = 1'b0;
    logic s_v = 1'b0, l_v = 1'b0;
    logic [W-1:0] s_d = '0, l_d = '0;
    int s_r = 0, s_c = 0, l_r = 0, l_c = 0;

    // model: frame images and expected outputs
    logic [W-1:0] img_s [4][4];
    logic [W-1:0] img_l [LN][LN];
    logic pend_s_v = 0, pend_s_l = 0, pend_l_v = 0, pend_l_l = 0;
    logic [W-1:0] pend_s_d = '0, pend_l_d = '0;
    logic exp_s_v = 0, exp_s_l = 0, exp_l_v = 0, exp_l_l = 0;
    logic [W-1:0] exp_s_d = '0, exp_l_d = '0;
    logic chk_en = 1'b0, seen_rst = 1'b0;

    int s_log[$];
    logic [W-1:0] s_logd[$];
    int s_lasts = 0, l_cnt = 0, l_lasts = 0;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pool4(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c, input logic [W-1:0] d);
        logic [W-1:0] r;
        logic signed [DW-1:0] m;
        for (int k = 0; k < CH; k++) begin
            m = a[k*DW +: DW];
            if ($signed(b[k*DW +: DW]) > m) m = b[k*DW +: DW];
            if ($signed(c[k*DW +: DW]) > m) m = c[k*DW +: DW];
            if ($signed(d[k*DW +: DW]) > m) m = d[k*DW +: DW];
            r[k*DW +: DW] = m;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] splat(input int v);
        logic [W-1:0] r;
        for (int k = 0; k < CH; k++) r[k*DW +: DW] = v;
        return r;
    endfunction

    // One clock: publish last cycle's expectation, apply new inputs, update model.
    task automatic step();
        @(posedge clk);
        #1;
        chk_en  = seen_rst;
        exp_s_v = pend_s_v; exp_s_l = pend_s_l; exp_s_d = pend_s_d;
        exp_l_v = pend_l_v; exp_l_l = pend_l_l; exp_l_d = pend_l_d;
        rst = nxt_rst;
        s_vin = s_v; s_in = s_d;
        l_vin = l_v; l_in = l_d;
        pend_s_v = 0; pend_s_l = 0; pend_l_v = 0; pend_l_l = 0;
        if (!nxt_rst) begin
            seen_rst = 1'b1;
            pend_s_d = '0;
            pend_l_d = '0;
        end else begin
            if (s_v) begin
                img_s[s_r][s_c] = s_d;
                if (s_r % 2 == 1 && s_c % 2 == 1) begin
                    pend_s_v = 1;
                    pend_s_l = (s_r == 3 && s_c == 3);
                    pend_s_d = pool4(img_s[s_r-1][s_c-1], img_s[s_r-1][s_c],
                                     img_s[s_r][s_c-1], img_s[s_r][s_c]);
                end
            end
            if (l_v) begin
                img_l[l_r][l_c] = l_d;
                if (l_r % 2 == 1 && l_c % 2 == 1) begin
                    pend_l_v = 1;
                    pend_l_l = (l_r == LN-1 && l_c == LN-1);
                    pend_l_d = pool4(img_l[l_r-1][l_c-1], img_l[l_r-1][l_c],
                                     img_l[l_r][l_c-1], img_l[l_r][l_c]);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("s.valid_out", W'(s_vout), W'(exp_s_v));
            check("s.last_out",  W'(s_lout), W'(exp_s_l));
            check("s.o_data",    s_out, exp_s_d);
            check("l.valid_out", W'(l_vout), W'(exp_l_v));
            check("l.last_out",  W'(l_lout), W'(exp_l_l));
            check("l.o_data",    l_out, exp_l_d);
        end
        if (s_vout === 1'b1) begin
            s_log.push_back(int'($signed(s_out[DW-1:0])));
            s_logd.push_back(s_out);
        end
        if (s_lout === 1'b1) s_lasts++;
        if (l_vout === 1'b1) l_cnt++;
        if (l_lout === 1'b1) l_lasts++;
    end

    task automatic clear_log();
        s_log.delete();
        s_logd.delete();
        s_lasts = 0;
    endtask

    task automatic check_seq(input string nm, input int e[8], input int n, input int lasts);
        check({nm, ".count"}, W'(s_log.size()), W'(n));
        check({nm, ".lasts"}, W'(s_lasts), W'(lasts));
        for (int i = 0; i < n && i < s_log.size(); i++)
            check({nm, ".ch0"}, W'(s_log[i]), W'(e[i]));
    endtask

    task automatic send_frame_s(input int base, input int gap);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                s_v = 1; s_d = splat(base + r*4 + c); s_r = r; s_c = c;
                step();
                s_v = 0;
                repeat (gap) step();
            end
        end
    endtask

    initial begin
        logic [W-1:0] px;
        // reset
        nxt_rst = 0;
        repeat (2) step();
        nxt_rst = 1;
        step();

        // continuous 4x4 frame
        clear_log();
        send_frame_s(0, 0);
        repeat (2) step();
        check_seq("cont", '{5, 7, 13, 15, 0, 0, 0, 0}, 4, 1);

        // signed compare, one populated window
        clear_log();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                px = '0;
                if (r < 2 && c < 2) begin
                    case (r*2 + c)
                        0: begin px[DW-1:0] = -32'sd3; px[7*DW +: DW] = 32'h7FFF_FFFF; end
                        1: begin px[DW-1:0] = -32'sd1; px[7*DW +: DW] = 32'h8000_0000; end
                        2: begin px[DW-1:0] = -32'sd7; px[7*DW +: DW] = 32'h0; end
                        default: begin px[DW-1:0] = -32'sd2; px[7*DW +: DW] = 32'h1; end
                    endcase
                end
                s_v = 1; s_d = px; s_r = r; s_c = c;
                step();
            end
        end
        s_v = 0;
        repeat (2) step();
        check("signed.count", W'(s_logd.size()), W'(4));
        if (s_logd.size() > 0) begin
            check("signed.ch0", W'(s_logd[0][DW-1:0]), W'(32'hFFFF_FFFF));
            check("signed.ch7", W'(s_logd[0][7*DW +: DW]), W'(32'h7FFF_FFFF));
        end

        // gapped input
        clear_log();
        send_frame_s(0, 3);
        repeat (2) step();
        check_seq("gap", '{5, 7, 13, 15, 0, 0, 0, 0}, 4, 1);

        // back-to-back frames
        clear_log();
        send_frame_s(0, 0);
        send_frame_s(100, 0);
        repeat (2) step();
        check_seq("b2b", '{5, 7, 13, 15, 105, 107, 113, 115}, 8, 2);

        // reset mid-frame, asserted together with a valid pixel
        for (int i = 0; i < 6; i++) begin
            s_v = 1; s_d = splat(50 + i); s_r = i / 4; s_c = i % 4;
            step();
        end
        nxt_rst = 0; s_d = splat(999);
        step();
        s_v = 0;
        step();
        nxt_rst = 1;
        clear_log();
        send_frame_s(0, 0);
        repeat (2) step();
        check_seq("midrst", '{5, 7, 13, 15, 0, 0, 0, 0}, 4, 1);

        // full-size random frame
        l_cnt = 0; l_lasts = 0;
        for (int r = 0; r < LN; r++) begin
            for (int c = 0; c < LN; c++) begin
                for (int k = 0; k < CH; k++) px[k*DW +: DW] = $urandom;
                l_v = 1; l_d = px; l_r = r; l_c = c;
                step();
            end
        end
        l_v = 0;
        repeat (2) step();
        check("large.count", W'(l_cnt), W'((LN/2) * (LN/2)));
        check("large.lasts", W'(l_lasts), W'(1));

        @(negedge clk);
        #1;
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
